// File: rtl/pingpong_buf_if.sv
// ---------------------------------------------------------------------------
// pingpong_buf_if
// Bundles the sample stream, the HPS handshake and the buffer-RAM write port
// of the ping-pong acquisition controller.
//
//   master : the environment side. It drives enable, the sample stream,
//            hps_ack and clr_status, and observes the controller outputs.
//   slave  : the controller side (pingpong_buf_ctrl).
//
// Signals
//   enable        acquisition run; low = idle, all buffers free
//   sample_valid  sample_data valid this cycle (no backpressure)
//   sample_data   incoming sample                          [DATA_W]
//   hps_ack       HPS PIO level; each toggle releases one buffer
//   clr_status    1-cycle pulse clearing overrun, overrun_cnt, release_err
//   wr_en         buffer RAM write strobe
//   wr_buf        target buffer (0=A, 1=B)
//   wr_addr       word address within the buffer          [ADDR_W]
//   wr_data       word to write                           [DATA_W]
//   full_flags    bit n = buffer n owned by the HPS       [2]
//   irq           1-cycle pulse per buffer completion
//   active_buf    buffer currently filling
//   overrun       sticky: sample dropped, both buffers full
//   overrun_cnt   dropped-sample count, saturating         [16]
//   release_err   sticky: hps_ack toggled with no buffer full
// ---------------------------------------------------------------------------
interface pingpong_buf_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              enable;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic              hps_ack;
    logic              clr_status;

    logic              wr_en;
    logic              wr_buf;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [1:0]        full_flags;
    logic              irq;
    logic              active_buf;
    logic              overrun;
    logic [15:0]       overrun_cnt;
    logic              release_err;

    modport master (
        output enable, sample_valid, sample_data, hps_ack, clr_status,
        input  wr_en, wr_buf, wr_addr, wr_data, full_flags, irq,
               active_buf, overrun, overrun_cnt, release_err
    );

    modport slave (
        input  enable, sample_valid, sample_data, hps_ack, clr_status,
        output wr_en, wr_buf, wr_addr, wr_data, full_flags, irq,
               active_buf, overrun, overrun_cnt, release_err
    );
endinterface

// File: rtl/pingpong_buf_ctrl.sv
// ---------------------------------------------------------------------------
// pingpong_buf_ctrl
// Sequences two acquisition buffers (A=0, B=1) between the FPGA and the HPS.
// Incoming samples are streamed into the buffer the FPGA currently owns.
// When a buffer's last word is written it is handed to the HPS (full flag +
// one-cycle irq) and filling continues in the other buffer if it is free,
// otherwise the controller waits and counts dropped samples. Each toggle of
// the HPS acknowledge level returns the oldest full buffer to the FPGA.
//
// Ports
//   clk      in  system clock
//   reset_n  in  asynchronous, active-low reset
//   bus      slave modport of pingpong_buf_if (stream in, RAM write port,
//            HPS flags/irq and status out); all outputs are registered
//
// Parameters
//   ADDR_W   buffer depth = 2**ADDR_W words
//   DATA_W   sample / buffer word width
// ---------------------------------------------------------------------------
module pingpong_buf_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    pingpong_buf_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL_A = 2'd1,
        ST_FILL_B = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [15:0]       CNT_MAX  = 16'hFFFF;

    // State and registered outputs
    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [1:0]        r_full;
    logic              r_oldest;
    logic [1:0]        r_ack_sync;
    logic              r_ack_prev;

    logic              r_wr_en;
    logic              r_wr_buf;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_irq;
    logic              r_active_buf;
    logic              r_overrun;
    logic [15:0]       r_overrun_cnt;
    logic              r_release_err;

    // Decoded per-cycle events
    logic              w_ack_edge;
    logic              w_release;
    logic              w_filling;
    logic              w_cur_buf;
    logic              w_last_word;
    logic              w_drop;
    logic [1:0]        w_full_rel;
    logic              w_oldest_rel;
    logic [1:0]        w_cur_mask;

    // hps_ack comes from another clock domain: two flops, then an edge
    // detect on the synchronized level. The release takes effect on the
    // third clk edge after the input toggles.
    assign w_ack_edge  = r_ack_sync[1] ^ r_ack_prev;
    assign w_release   = w_ack_edge && (r_full != 2'b00);

    assign w_filling   = (r_state == ST_FILL_A) || (r_state == ST_FILL_B);
    assign w_cur_buf   = (r_state == ST_FILL_B);
    assign w_cur_mask  = w_cur_buf ? 2'b10 : 2'b01;
    assign w_last_word = (r_ptr == PTR_LAST);
    assign w_drop      = bus.enable && (r_state == ST_WAIT) && bus.sample_valid;

    // Ownership after this cycle's release, before any completion is added.
    // A release always returns the oldest full buffer, so a same-cycle
    // completion can never be released in the cycle it becomes full.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_full_rel   = r_full;
        w_oldest_rel = r_oldest;
        if (w_release) begin
            w_full_rel   = r_full & ~(r_oldest ? 2'b10 : 2'b01);
            w_oldest_rel = ~r_oldest;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side reads the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_full        <= 2'b00;
            r_oldest      <= 1'b0;
            r_ack_sync    <= 2'b00;
            r_ack_prev    <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_buf      <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_irq         <= 1'b0;
            r_active_buf  <= 1'b0;
            r_overrun     <= 1'b0;
            r_overrun_cnt <= '0;
            r_release_err <= 1'b0;
        end else begin
            r_ack_sync <= {r_ack_sync[0], bus.hps_ack};
            r_ack_prev <= r_ack_sync[1];

            // Strobes default low; only a write or completion raises them.
            r_wr_en <= 1'b0;
            r_irq   <= 1'b0;

            // Sticky status. A clear in the same cycle as a new event wins
            // and that event is not counted.
            if (bus.clr_status) begin
                r_overrun     <= 1'b0;
                r_overrun_cnt <= '0;
                r_release_err <= 1'b0;
            end else begin
                if (w_drop) begin
                    r_overrun <= 1'b1;
                    if (r_overrun_cnt != CNT_MAX) begin
                        r_overrun_cnt <= r_overrun_cnt + 16'd1;
                    end
                end
                if (w_ack_edge && (r_full == 2'b00)) begin
                    r_release_err <= 1'b1;
                end
            end

            if (!bus.enable) begin
                // Stopping discards partial data and frees both buffers.
                r_state      <= ST_IDLE;
                r_ptr        <= '0;
                r_full       <= 2'b00;
                r_oldest     <= 1'b0;
                r_active_buf <= 1'b0;
            end else begin
                r_full   <= w_full_rel;
                r_oldest <= w_oldest_rel;

                case (r_state)
                    ST_IDLE: begin
                        r_state      <= ST_FILL_A;
                        r_active_buf <= 1'b0;
                    end

                    ST_FILL_A, ST_FILL_B: begin
                        if (bus.sample_valid) begin
                            r_wr_en   <= 1'b1;
                            r_wr_buf  <= w_cur_buf;
                            r_wr_addr <= r_ptr;
                            r_wr_data <= bus.sample_data;
                            r_ptr     <= r_ptr + 1'b1;   // wraps to 0 after the last word

                            if (w_last_word) begin
                                // Release (already folded into w_full_rel)
                                // applies before the completing buffer is marked.
                                r_irq  <= 1'b1;
                                r_full <= w_full_rel | w_cur_mask;
                                if (w_full_rel == 2'b00) begin
                                    r_oldest <= w_cur_buf;
                                end
                                if (!w_full_rel[~w_cur_buf]) begin
                                    r_state      <= w_cur_buf ? ST_FILL_A : ST_FILL_B;
                                    r_active_buf <= ~w_cur_buf;
                                end else begin
                                    r_state <= ST_WAIT;
                                end
                            end
                        end
                    end

                    ST_WAIT: begin
                        // Both buffers are full here, so the buffer freed
                        // first is always the oldest one.
                        if (w_release) begin
                            r_state      <= r_oldest ? ST_FILL_B : ST_FILL_A;
                            r_active_buf <= r_oldest;
                            r_ptr        <= '0;
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.wr_en       = r_wr_en;
    assign bus.wr_buf      = r_wr_buf;
    assign bus.wr_addr     = r_wr_addr;
    assign bus.wr_data     = r_wr_data;
    assign bus.full_flags  = r_full;
    assign bus.irq         = r_irq;
    assign bus.active_buf  = r_active_buf;
    assign bus.overrun     = r_overrun;
    assign bus.overrun_cnt = r_overrun_cnt;
    assign bus.release_err = r_release_err;

    // The buffer being filled is never one the HPS owns.
    a_fill_owned: assert property (@(posedge clk) disable iff (!reset_n)
        w_filling |-> !r_full[w_cur_buf]);

    // A completion irq always accompanies the write of a last word.
    a_irq_with_write: assert property (@(posedge clk) disable iff (!reset_n)
        r_irq |-> (r_wr_en && (r_wr_addr == PTR_LAST)));

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pingpong_buf_ctrl
// Directed bench for pingpong_buf_ctrl with ADDR_W=3 (8-word buffers).
// Stimulus pushes each expected RAM write into a queue; a monitor on the
// falling edge pops and compares whenever wr_en is high. Flags and status
// are compared at chosen points by the stimulus process.
// ---------------------------------------------------------------------------
module tb_pingpong_buf_ctrl;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              buf_sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              irq;
    } wr_exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    pingpong_buf_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pingpong_buf_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    wr_exp_t exp_q[$];
    wr_exp_t mon_e;
    int      n_checks = 0;
    int      n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (reset_n && bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: buf %0d addr %0d data 0x%0h, expected no write (t=%0t)",
                         bus.wr_buf, bus.wr_addr, bus.wr_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_buf",  {31'd0, bus.wr_buf},  {31'd0, mon_e.buf_sel});
                check("wr_addr", {29'd0, bus.wr_addr}, {29'd0, mon_e.addr});
                check("wr_data", bus.wr_data, mon_e.data);
                check("wr_irq",  {31'd0, bus.irq},     {31'd0, mon_e.irq});
            end
        end else if (reset_n && bus.irq === 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL irq_without_write: irq=1 with wr_en=0, expected irq only on a write (t=%0t)", $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input bit exp_wr,
                        input logic b, input logic [ADDR_W-1:0] a);
        bus.sample_valid = 1'b1;
        bus.sample_data  = d;
        if (exp_wr) exp_q.push_back('{b, a, d, (a == 3'd7)});
        tick();
        bus.sample_valid = 1'b0;
    endtask

    // Sends n samples data base+i to buffer b starting at address a0.
    task automatic send_run(input logic b, input int a0, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            send(DATA_W'(base + i), 1'b1, b, ADDR_W'(a0 + i));
        end
    endtask

    task automatic toggle_ack();
        bus.hps_ack = ~bus.hps_ack;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},       {31'd0, bus.wr_en},       32'd0);
        check({tag, "_wr_buf"},      {31'd0, bus.wr_buf},      32'd0);
        check({tag, "_wr_addr"},     {29'd0, bus.wr_addr},     32'd0);
        check({tag, "_wr_data"},     bus.wr_data,              32'd0);
        check({tag, "_full_flags"},  {30'd0, bus.full_flags},  32'd0);
        check({tag, "_irq"},         {31'd0, bus.irq},         32'd0);
        check({tag, "_active_buf"},  {31'd0, bus.active_buf},  32'd0);
        check({tag, "_overrun"},     {31'd0, bus.overrun},     32'd0);
        check({tag, "_overrun_cnt"}, {16'd0, bus.overrun_cnt}, 32'd0);
        check({tag, "_release_err"}, {31'd0, bus.release_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.enable       = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        bus.hps_ack      = 1'b0;
        bus.clr_status   = 1'b0;

        // Reset values
        repeat (2) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // 1: first buffer fills A at addresses 0..7, irq on addr 7
        bus.enable = 1'b1;
        tick();
        send_run(1'b0, 0, 8, 0);
        check("t1_full_flags", {30'd0, bus.full_flags}, 32'h1);
        check("t1_active_buf", {31'd0, bus.active_buf}, 32'd1);

        // 2: B fills with no ack, then three samples are dropped
        send_run(1'b1, 0, 8, 8);
        check("t2_full_flags", {30'd0, bus.full_flags}, 32'h3);
        for (int i = 0; i < 3; i++) send(DATA_W'(16 + i), 1'b0, 1'b0, '0);
        check("t2_overrun",     {31'd0, bus.overrun},     32'd1);
        check("t2_overrun_cnt", {16'd0, bus.overrun_cnt}, 32'd3);

        // 3: ack toggle releases A on the third edge; fill resumes at A addr 0
        toggle_ack();
        repeat (2) tick();
        check("t3_flags_before_release", {30'd0, bus.full_flags}, 32'h3);
        tick();
        check("t3_flags_after_release", {30'd0, bus.full_flags}, 32'h2);
        send(DATA_W'(100), 1'b1, 1'b0, 3'd0);
        check("t3_active_buf", {31'd0, bus.active_buf}, 32'd0);
        toggle_ack();
        repeat (3) tick();
        check("t3_second_release", {30'd0, bus.full_flags}, 32'h0);

        // Set up FILL_A with B full: finish A, release A during B, finish B
        send_run(1'b0, 1, 7, 101);
        check("setup_a_full", {30'd0, bus.full_flags}, 32'h1);
        send_run(1'b1, 0, 4, 200);
        toggle_ack();
        repeat (3) tick();
        check("setup_a_released", {30'd0, bus.full_flags}, 32'h0);
        send_run(1'b1, 4, 4, 204);
        check("setup_b_full", {30'd0, bus.full_flags}, 32'h2);

        // 4: release lands on the same edge as A's last write
        send_run(1'b0, 0, 5, 300);
        toggle_ack();
        send(DATA_W'(305), 1'b1, 1'b0, 3'd5);
        send(DATA_W'(306), 1'b1, 1'b0, 3'd6);
        check("t4_flags_before", {30'd0, bus.full_flags}, 32'h2);
        send(DATA_W'(307), 1'b1, 1'b0, 3'd7);
        check("t4_flags_after", {30'd0, bus.full_flags}, 32'h1);
        check("t4_active_buf",  {31'd0, bus.active_buf}, 32'd1);
        send(DATA_W'(400), 1'b1, 1'b1, 3'd0);

        // 5: release with nothing full sets release_err; clr_status clears status
        toggle_ack();
        repeat (3) tick();
        check("t5_flags_freed",  {30'd0, bus.full_flags},  32'h0);
        check("t5_no_rel_err",   {31'd0, bus.release_err}, 32'd0);
        toggle_ack();
        repeat (3) tick();
        check("t5_rel_err",         {31'd0, bus.release_err}, 32'd1);
        check("t5_overrun_sticky",  {16'd0, bus.overrun_cnt}, 32'd3);
        bus.clr_status = 1'b1;
        tick();
        bus.clr_status = 1'b0;
        check("t5_clr_rel_err", {31'd0, bus.release_err}, 32'd0);
        check("t5_clr_overrun", {31'd0, bus.overrun},     32'd0);
        check("t5_clr_cnt",     {16'd0, bus.overrun_cnt}, 32'd0);

        // 6: drop enable mid-fill, restart at A addr 0, then reset mid-fill
        bus.enable = 1'b0;
        tick();
        bus.enable = 1'b1;
        tick();
        send_run(1'b0, 0, 5, 500);
        bus.enable = 1'b0;
        tick();
        check("t6_idle_flags", {30'd0, bus.full_flags}, 32'h0);
        send(DATA_W'(599), 1'b0, 1'b0, '0);
        bus.enable = 1'b1;
        tick();
        send(DATA_W'(600), 1'b1, 1'b0, 3'd0);
        send(DATA_W'(601), 1'b1, 1'b0, 3'd1);
        send(DATA_W'(602), 1'b0, 1'b0, '0);
        check("t6_write_in_flight", {31'd0, bus.wr_en}, 32'd1);
        reset_n     = 1'b0;
        bus.hps_ack = 1'b0;
        #1;
        check_all_zero("t6_async_reset");
        repeat (2) tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
